vga_sync_decoder: RTL
=====================

# vga_sync_decoder

Recovers pixel coordinates from an incoming VGA hsync/vsync pair, the receive-side counterpart of the column/row counters that drive our VGA sync generation. Sync inputs arrive one pixel per `clk_i`, already synchronous to `clk_i`. The block flywheels free-running column/row counters and re-aligns them on sync leading edges. It reports lock, visible-area, frame start, and alignment errors to downstream capture logic, such as a framebuffer writer.

## Interface
- `H_WHOLE_LINE`, 800: clocks per line.
- `V_WHOLE_FRAME`, 525: lines per frame.
- `H_VISIBLE`, 640: visible columns.
- `V_VISIBLE`, 480: visible rows.
- `H_SYNC_START`, 656: column of the first hsync-active pixel.
- `V_SYNC_START`, 490: row of the first vsync-active line.
- `SYNC_ACTIVE_LOW`, 1: 1 means syncs are active when low.
- `LOCK_COUNT`, 2: consecutive clean edges required for lock, applied per axis.

Ports:
- `clk_i` input 1: pixel clock.
- `reset_i` input 1: reset, asynchronous, active-low.
- `hsync_i` input 1: horizontal sync, synchronous to `clk_i`.
- `vsync_i` input 1: vertical sync, synchronous to `clk_i`.
- `column_o` output 10: recovered column, 0..H_WHOLE_LINE-1.
- `row_o` output 10: recovered row, 0..V_WHOLE_FRAME-1.
- `visible_o` output 1: current pixel is in the visible area and the decoder is locked.
- `frame_start_o` output 1: one-cycle pulse when (column,row) becomes (0,0) while locked.
- `locked_o` output 1: both axes locked.
- `align_err_o` output 1: one-cycle pulse when a sync edge forces a counter correction while locked.

## Operation
- Polarity: sync inputs are normalised to active-high internally (inverted when `SYNC_ACTIVE_LOW`=1).
- Edge detection: each sync input is registered once. A leading edge is sampled when the registered value is inactive and the input is active.
- Column counter:
  - Increments every cycle and wraps from H_WHOLE_LINE-1 to 0.
  - On an hsync leading edge, the column is loaded with H_SYNC_START regardless of its free-run value.
- Row counter:
  - Increments when the column wraps, and wraps from V_WHOLE_FRAME-1 to 0.
  - On a vsync leading edge, the row is loaded with V_SYNC_START.
  - If a vsync edge and a column wrap occur on the same cycle, the vsync load wins.
- Clean edge: the free-running value already equals the load value, so no change to the count is needed.
- Horizontal lock (h_lock_cnt, saturating at LOCK_COUNT):
  - A clean hsync edge increments h_lock_cnt.
  - A corrected hsync edge clears it to 0.
  - h_locked = (h_lock_cnt == LOCK_COUNT).
- Vertical lock: v_lock_cnt and v_locked behave the same way, driven by vsync edges.
- Watchdogs: h_locked clears if no hsync edge occurs within 2*H_WHOLE_LINE cycles, and v_locked clears if no vsync edge occurs within 2*V_WHOLE_FRAME lines. Both watchdogs reset on every edge of their axis.
- Outputs derived from lock state:
  - locked_o = h_locked & v_locked.
  - align_err_o pulses on a corrected edge of either axis only if locked_o was 1 on that cycle. The same edge also drops lock.
  - visible_o = locked_o & (column_o < H_VISIBLE) & (row_o < V_VISIBLE).
- Width rule: all parameters must be ≤1024. Counters are 10 bits, and comparisons use unsigned arithmetic.

## Timing
- Reset (reset_i low, asynchronous): column_o=0, row_o=0, all lock counters 0, locked_o=0, visible_o=0, frame_start_o=0, align_err_o=0. Registered sync inputs reset to inactive.
- Latency: the pixel sampled on clock edge N is described by column_o/row_o/visible_o after edge N, a 1-cycle latency.
- After an hsync leading edge is sampled, column_o=H_SYNC_START on that same cycle.
- Lock acquisition: from reset, with clean syncs, h_locked is set at the (LOCK_COUNT+1)th hsync edge. The first edge is always a correction unless the counter is coincidentally aligned.
- Deassertion:
  - An edge that causes a correction drops locked_o after the edge on which it is sampled.
  - A watchdog expiry drops locked_o on the following cycle.
- Reset mid-frame returns all outputs to their reset values immediately, and lock must be re-acquired from scratch.

## Test plan
- Nominal 640x480 syncs from the generator with polarity low → locked_o=1 by frame 3. Column_o tracks 0..799 and row_o tracks 0..524. visible_o is high for exactly 640×480 cycles per frame. frame_start_o pulses once per frame.
- Locked stream, hsync moved 3 clocks late on one line → align_err_o pulses once and column_o is reloaded to 656. locked_o drops, then re-locks after 2 further clean lines, provided v_locked still holds.
- hsync held inactive for 1600 cycles while locked → locked_o falls at cycle 1600 ±1, and the counters keep free-running.
- vsync edge coincident with a column wrap at row 489 → row_o=490, not 490+1, and no align_err_o pulse.
- reset_i asserted at column 300, row 100 while locked → all outputs go to 0 asynchronously. After release, locked_o stays 0 until lock is re-acquired.
- `SYNC_ACTIVE_LOW`=0 with inverted syncs → results identical to the nominal case.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: flywheel column/row counters re-aligned on
// hsync/vsync leading edges, with per-axis lock qualification and watchdogs.
module vga_sync_decoder #(
  parameter int unsigned H_WHOLE_LINE    = 800,
  parameter int unsigned V_WHOLE_FRAME   = 525,
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned H_SYNC_START    = 656,
  parameter int unsigned V_SYNC_START    = 490,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_COUNT      = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] column_o,
  output logic [9:0] row_o,
  output logic       visible_o,
  output logic       frame_start_o,
  output logic       locked_o,
  output logic       align_err_o
);

  localparam int unsigned LW  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int unsigned WDW = 12;  // holds 2*1024

  localparam logic [9:0]     H_LAST    = 10'(H_WHOLE_LINE - 1);
  localparam logic [9:0]     V_LAST    = 10'(V_WHOLE_FRAME - 1);
  localparam logic [9:0]     H_LOAD    = 10'(H_SYNC_START);
  localparam logic [9:0]     V_LOAD    = 10'(V_SYNC_START);
  localparam logic [LW-1:0]  LOCK_MAX  = LW'(LOCK_COUNT);
  localparam logic [WDW-1:0] HWD_LIMIT = WDW'(2 * H_WHOLE_LINE);
  localparam logic [WDW-1:0] VWD_LIMIT = WDW'(2 * V_WHOLE_FRAME);
  localparam logic [WDW-1:0] HWD_LAST  = WDW'(2 * H_WHOLE_LINE - 1);
  localparam logic [WDW-1:0] VWD_LAST  = WDW'(2 * V_WHOLE_FRAME - 1);

  // Registered state
  logic           hs_q, vs_q;
  logic [9:0]     col_q, row_q;
  logic [LW-1:0]  h_lock_q, v_lock_q;
  logic [WDW-1:0] h_wd_q, v_wd_q;
  logic           align_err_q;

  // Next-state terms
  logic           hs_act, vs_act, h_edge, v_edge;
  logic           col_wrap, line_tick;
  logic [9:0]     col_free, row_free, col_d, row_d;
  logic           h_fix, v_fix, h_clean, v_clean;
  logic           h_wd_expire, v_wd_expire;
  logic [LW-1:0]  h_lock_d, v_lock_d;
  logic [WDW-1:0] h_wd_d, v_wd_d;
  logic           h_locked, v_locked;

  assign hs_act = SYNC_ACTIVE_LOW ? ~hsync_i : hsync_i;
  assign vs_act = SYNC_ACTIVE_LOW ? ~vsync_i : vsync_i;
  assign h_edge = hs_act & ~hs_q;
  assign v_edge = vs_act & ~vs_q;

  assign h_locked = (h_lock_q == LOCK_MAX);
  assign v_locked = (v_lock_q == LOCK_MAX);

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    col_wrap  = (col_q == H_LAST);
    col_free  = col_wrap ? '0 : col_q + 10'd1;
    col_d     = h_edge ? H_LOAD : col_free;
    // A line ends only when the column really goes from last to zero.
    line_tick = col_wrap && (col_d == '0);

    row_free  = row_q;
    if (line_tick) row_free = (row_q == V_LAST) ? '0 : row_q + 10'd1;
    row_d     = v_edge ? V_LOAD : row_free;

    h_fix     = h_edge && (col_free != H_LOAD);
    v_fix     = v_edge && (row_free != V_LOAD);
    h_clean   = h_edge && !h_fix;
    v_clean   = v_edge && !v_fix;

    h_wd_expire = !h_edge && (h_wd_q == HWD_LAST);
    v_wd_expire = !v_edge && line_tick && (v_wd_q == VWD_LAST);

    h_wd_d = h_wd_q;
    if (h_edge)                    h_wd_d = '0;
    else if (h_wd_q != HWD_LIMIT)  h_wd_d = h_wd_q + 1'b1;

    v_wd_d = v_wd_q;
    if (v_edge)                                v_wd_d = '0;
    else if (line_tick && v_wd_q != VWD_LIMIT) v_wd_d = v_wd_q + 1'b1;

    h_lock_d = h_lock_q;
    if (h_fix || h_wd_expire)             h_lock_d = '0;
    else if (h_clean && !h_locked)        h_lock_d = h_lock_q + 1'b1;

    v_lock_d = v_lock_q;
    if (v_fix || v_wd_expire)             v_lock_d = '0;
    else if (v_clean && !v_locked)        v_lock_d = v_lock_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      h_lock_q    <= '0;
      v_lock_q    <= '0;
      h_wd_q      <= '0;
      v_wd_q      <= '0;
      align_err_q <= 1'b0;
    end else begin
      hs_q        <= hs_act;
      vs_q        <= vs_act;
      col_q       <= col_d;
      row_q       <= row_d;
      h_lock_q    <= h_lock_d;
      v_lock_q    <= v_lock_d;
      h_wd_q      <= h_wd_d;
      v_wd_q      <= v_wd_d;
      align_err_q <= (h_fix || v_fix) && locked_o;
    end
  end

  assign column_o      = col_q;
  assign row_o         = row_q;
  assign locked_o      = h_locked & v_locked;
  assign align_err_o   = align_err_q;
  // The counter sits at (0,0) for exactly one cycle per frame.
  assign frame_start_o = locked_o && (col_q == '0) && (row_q == '0);
  assign visible_o     = locked_o && (32'(col_q) < H_VISIBLE) && (32'(row_q) < V_VISIBLE);

endmodule
